// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared types and helpers for the serial transmit path.
//   - parity_e   : latched parity selection (none / even / odd)
//   - tx_state_e : transmit sequencer states; BREAK exists only when
//                  SERIAL_TX_BREAK_EN is defined
//   - DATA_W_C   : bits per frame (fixed at 8)
//   - decode_parity : maps the 2-bit parity_mode field to parity_e
//   - baud_reload   : baud counter reload value, max(div,1)-1
package serial_pkg;

  localparam int DATA_W_C = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

`ifdef SERIAL_TX_BREAK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`endif

  // Mode 3 is reserved and behaves as no parity.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    parity_e p;
    case (mode)
      2'd1:    p = PAR_EVEN;
      2'd2:    p = PAR_ODD;
      default: p = PAR_NONE;
    endcase
    return p;
  endfunction

  // A divisor of 0 is treated as 1, so both reload to 0 (one clock per bit).
  function automatic logic [15:0] baud_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : (div - 16'd1);
  endfunction

endpackage

// File: rtl/serial_tx_ctrl_fifo.sv
// serial_sync_fifo
//   Single-clock first-word-fall-through FIFO. data_o always shows the
//   head entry while empty_o is low. A push while full and a pop while
//   empty are ignored; push and pop together keep the count unchanged.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     push_i, data_i write request and data
//     pop_i          read request (head advances)
//     data_o         head entry
//     count_o        occupancy 0..DEPTH
//     full_o, empty_o
module serial_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the current count, so a push into a full FIFO
  // is dropped even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl
//   UART transmit controller: buffers bytes in a FIFO and serialises each
//   one as start bit, 8 data bits LSB first, optional parity bit and one or
//   two stop bits. Every bit lasts max(baud_div,1) clocks. Frame config is
//   latched when a byte is popped, so mid-frame config changes only affect
//   later frames. Back-to-back frames run with no idle gap.
//   Optional feature macro: SERIAL_TX_BREAK_EN (adds brk input and BREAK).
//   Ports:
//     clock, reset          clock, asynchronous active-high reset
//     wr_data, wr_valid     byte push; accepted when wr_ready
//     wr_ready              !fifo_full
//     enable                permits new frames to start
//     baud_div              clocks per bit (0 behaves as 1)
//     parity_mode           0/3 none, 1 even, 2 odd
//     two_stop              two stop bits when high
//     ovf_clr               clears sticky ovf (a new overflow wins)
//     brk                   line break request (SERIAL_TX_BREAK_EN only)
//     tx                    serial line, idle high
//     busy                  frame (or break) in progress
//     fifo_count/full/empty FIFO status
//     ovf                   sticky overflow flag
module serial_tx_ctrl
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = DATA_W_C
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          enable,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          ovf_clr,
`ifdef SERIAL_TX_BREAK_EN
  input  logic                          brk,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          ovf
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  tx_state_e         state_q;
  logic              tx_q;
  logic              busy_q;
  logic [15:0]       baud_cnt_q;
  logic [15:0]       div_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shreg_q;
  parity_e           par_mode_q;
  logic              par_bit_q;
  logic              two_stop_q;
  logic              ovf_q;
  logic              ovf_d;

  logic [DATA_W-1:0] fifo_dout;
  logic              bit_end;
  logic              last_stop;
  logic              launch_ok;
  logic              pop;
  parity_e           par_mode_in;

  serial_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (wr_valid),
    .pop_i   (pop),
    .data_i  (wr_data),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

  assign par_mode_in = decode_parity(parity_mode);

  always_comb begin
    bit_end   = (baud_cnt_q == '0);
    // bit_q[0] counts stop bits: the last one is index 1 with two stops.
    last_stop = (state_q == STOP) && bit_end && (bit_q[0] == two_stop_q);
    launch_ok = enable && !fifo_empty;
`ifdef SERIAL_TX_BREAK_EN
    launch_ok = launch_ok && !brk;
`endif
    pop = launch_ok && ((state_q == IDLE) || last_stop);
  end

  // Overflow set has priority over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)                ovf_d = 1'b0;
    if (wr_valid && fifo_full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end

        START: begin
          if (bit_end) begin
            state_q    <= DATA;
            bit_q      <= '0;
            tx_q       <= shreg_q[0];
            baud_cnt_q <= div_q;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end

        // shreg_q is shifted at each data-bit boundary so bit 0 is always
        // the bit on the line; the parity bit was computed at launch.
        DATA: begin
          if (bit_end) begin
            baud_cnt_q <= div_q;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (par_mode_q != PAR_NONE) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            baud_cnt_q <= div_q;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              bit_q      <= 3'd1;
              baud_cnt_q <= div_q;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
              bit_q   <= '0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end

`ifdef SERIAL_TX_BREAK_EN
        // bit_q[0] = 0 while the line is held low, 1 during the trailing
        // one-bit mark period after brk drops.
        BREAK: begin
          if (!bit_q[0]) begin
            if (!brk) begin
              bit_q      <= 3'd1;
              tx_q       <= 1'b1;
              baud_cnt_q <= div_q;
            end
          end else if (bit_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            bit_q   <= '0;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
`endif

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      // Launch overrides the IDLE/STOP branches above so a new frame can
      // follow the last stop bit with no idle cycle.
      if (pop) begin
        state_q    <= START;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        bit_q      <= '0;
        shreg_q    <= fifo_dout;
        par_mode_q <= par_mode_in;
        par_bit_q  <= (^fifo_dout) ^ (par_mode_in == PAR_ODD);
        two_stop_q <= two_stop;
        div_q      <= baud_reload(baud_div);
        baud_cnt_q <= baud_reload(baud_div);
      end

`ifdef SERIAL_TX_BREAK_EN
      if (brk && ((state_q == IDLE) || last_stop)) begin
        state_q    <= BREAK;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        bit_q      <= '0;
        div_q      <= baud_reload(baud_div);
        baud_cnt_q <= baud_reload(baud_div);
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
module tb_serial_tx_ctrl;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        enable = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ovf;

  serial_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .enable      (enable),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .ovf_clr     (ovf_clr),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .ovf         (ovf)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue of bytes, the future tx line
  // as a queue of levels (one entry per clock), sticky overflow flag.
  logic [7:0] m_fifo[$];
  logic       m_line[$];
  logic       m_ovf = 1'b0;
  logic       tx_log[$];
  logic       busy_log[$];

  function automatic void add_frame(input logic [7:0] b, input logic [15:0] div,
                                    input logic [1:0] pm, input logic ts);
    int d;
    logic lv[$];
    d = (div == 16'd0) ? 1 : int'(div);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (pm == 2'd1) lv.push_back(^b);
    else if (pm == 2'd2) lv.push_back(~^b);
    lv.push_back(1'b1);
    if (ts) lv.push_back(1'b1);
    foreach (lv[i]) for (int k = 0; k < d; k++) m_line.push_back(lv[i]);
  endfunction

  always @(negedge clock) begin
    logic exp_tx, exp_busy, line_free, full_before;
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 1'b0;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_empty", fifo_empty, 1'b1);
      check("rst_full", fifo_full, 1'b0);
      check("rst_ovf", ovf, 1'b0);
    end else begin
      exp_busy = (m_line.size() > 0);
      exp_tx   = exp_busy ? m_line[0] : 1'b1;
      check("tx", tx, exp_tx);
      check("busy", busy, exp_busy);
      check("fifo_count", fifo_count, m_fifo.size());
      check("fifo_full", fifo_full, m_fifo.size() == DEPTH);
      check("fifo_empty", fifo_empty, m_fifo.size() == 0);
      check("wr_ready", wr_ready, m_fifo.size() != DEPTH);
      check("ovf", ovf, m_ovf);
      tx_log.push_back(tx);
      busy_log.push_back(busy);
      // advance the model across the coming rising edge
      line_free   = (m_line.size() <= 1);
      full_before = (m_fifo.size() == DEPTH);
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (line_free && enable && m_fifo.size() > 0)
        add_frame(m_fifo.pop_front(), baud_div, parity_mode, two_stop);
      if (wr_valid && full_before) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (wr_valid && !full_before) m_fifo.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  function automatic logic tx_at(input int i);
    if (i >= 0 && i < tx_log.size()) return tx_log[i];
    return 1'bx;
  endfunction

  function automatic int busy_cycles(input int from);
    int n = 0;
    for (int i = from; i < busy_log.size(); i++) if (busy_log[i] === 1'b1) n++;
    return n;
  endfunction

  // Finds the first start bit at or after 'from' and samples mid-bit.
  task automatic decode(input int from, input int d, output logic [7:0] b,
                        output logic p, output int s);
    s = -1;
    for (int i = from; i < tx_log.size(); i++)
      if (tx_log[i] === 1'b0) begin s = i; break; end
    b = 'x;
    p = 1'bx;
    if (s >= 0) begin
      for (int k = 0; k < 8; k++) b[k] = tx_at(s + d*(1+k) + d/2);
      p = tx_at(s + 9*d + d/2);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       p;
    int         s, s0, mark;
    logic [7:0] exp3 [3];

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_count", fifo_count, 0);

    // single byte, no parity, D=4
    baud_div = 16'd4; parity_mode = 2'd0; two_stop = 1'b0; enable = 1'b1;
    mark = tx_log.size();
    push(8'h55);
    repeat (60) tick();
    decode(mark, 4, b, p, s);
    check("t1_byte", b, 8'h55);
    check("t1_busy40", busy_cycles(mark), 40);
    check("t1_start_low", tx_at(s + 3), 1'b0);
    check("t1_bit0_high", tx_at(s + 4), 1'b1);
    check("t1_stop_high", tx_at(s + 39), 1'b1);

    // parity variants, D=2, byte 0x07
    baud_div = 16'd2;
    for (int v = 0; v < 3; v++) begin
      parity_mode = (v == 1) ? 2'd2 : 2'd1;
      two_stop    = (v == 2);
      mark = tx_log.size();
      push(8'h07);
      repeat (40) tick();
      decode(mark, 2, b, p, s);
      check("t2_byte", b, 8'h07);
      check("t2_parity", p, (v == 1) ? 1'b0 : 1'b1);
      check("t2_len", busy_cycles(mark), (v == 2) ? 24 : 22);
    end
    parity_mode = 2'd0; two_stop = 1'b0;

    // overflow with enable low
    enable = 1'b0; baud_div = 16'd1;
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    tick();
    check("ovf_count16", fifo_count, 16);
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_set", ovf, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
    ovf_clr = 1'b1; wr_data = 8'hEE; wr_valid = 1'b1; tick();
    ovf_clr = 1'b0; wr_valid = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);
    mark = tx_log.size();
    enable = 1'b1;
    repeat (170) tick();
    check("ovf_drain_busy", busy_cycles(mark), 160);
    s0 = -1;
    for (int i = 0; i < 16; i++) begin
      decode((s0 < 0) ? mark : s0 + 10*i, 1, b, p, s);
      if (s0 < 0) s0 = s;
      check("ovf_drain_byte", b, 8'h10 + 8'(i));
      check("ovf_drain_gap", s, s0 + 10*i);
    end

    // back-to-back, D=1
    enable = 1'b0;
    exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;
    for (int i = 0; i < 3; i++) push(exp3[i]);
    mark = tx_log.size();
    enable = 1'b1;
    repeat (40) tick();
    check("b2b_busy30", busy_cycles(mark), 30);
    decode(mark, 1, b, p, s0);
    for (int i = 0; i < 3; i++) begin
      decode(s0 + 10*i, 1, b, p, s);
      check("b2b_byte", b, exp3[i]);
      check("b2b_start", s, s0 + 10*i);
    end

    // enable dropped mid-frame
    enable = 1'b0; baud_div = 16'd3;
    push(8'h5A); push(8'h6B);
    mark = tx_log.size();
    enable = 1'b1;
    repeat (10) tick();
    check("en_drop_busy_mid", busy, 1'b1);
    enable = 1'b0;
    repeat (40) tick();
    decode(mark, 3, b, p, s);
    check("en_drop_byte", b, 8'h5A);
    check("en_drop_idle_busy", busy, 1'b0);
    check("en_drop_idle_tx", tx, 1'b1);
    check("en_drop_retained", fifo_count, 1);

    // asynchronous reset during DATA
    baud_div = 16'd4; enable = 1'b1;
    push(8'hF0);
    repeat (12) tick();
    check("arst_pre_busy", busy, 1'b1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_count", fifo_count, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // baud_div = 0 behaves as 1
    baud_div = 16'd0; parity_mode = 2'd0; two_stop = 1'b0; enable = 1'b1;
    mark = tx_log.size();
    push(8'h3C);
    repeat (20) tick();
    decode(mark, 1, b, p, s);
    check("div0_byte", b, 8'h3C);
    check("div0_len", busy_cycles(mark), 10);

    // randomized traffic with mid-frame config changes
    for (int c = 0; c < 3000; c++) begin
      wr_valid = ($urandom_range(0, 9) < 3);
      wr_data  = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) begin
        baud_div    = 16'($urandom_range(0, 3));
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
      tick();
    end
    wr_valid = 1'b0; ovf_clr = 1'b0; enable = 1'b1;
    repeat (700) tick();
    check("final_empty", fifo_empty, 1'b1);
    check("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
